// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit.
// Request fields are held stable until ready.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: width decode, lane steering,
// handshaked memory access with timeout and fault reporting.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               misaligned,
  output logic               illegal,
  output logic               bus_error,
  load_store_unit_if.master  mem
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        ill_q;
  logic        berr_q;

  logic        bad_f3;
  logic        bad_align;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] ld;
  logic        expire;

  always_comb begin
    bad_f3 = 1'b0;
    if (req_we)
      bad_f3 = funct3[2] || (funct3[1:0] == 2'b11);
    else
      bad_f3 = (funct3[1:0] == 2'b11)
            || (funct3[2:1] == 2'b11);
    bad_align = 1'b0;
    be_d      = 4'b1111;
    wdata_d   = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        bad_align = addr[0];
        be_d      = 4'b0011 << addr[1:0];
        wdata_d   = {2{wdata[15:0]}};
      end
      default: begin
        bad_align = addr[1:0] != 2'b00;
      end
    endcase
  end

  // Move the addressed lane down to bit 0 before extension.
  assign lane = mem.rdata >> {off_q, 3'b000};

  always_comb begin
    ld = mem.rdata;
    case (f3_q)
      3'b000: ld = {{24{lane[7]}}, lane[7:0]};
      3'b001: ld = {{16{lane[15]}}, lane[15:0]};
      3'b100: ld = {24'd0, lane[7:0]};
      3'b101: ld = {16'd0, lane[15:0]};
      default: ld = mem.rdata;
    endcase
  end

  assign expire = (cnt + 16'd1) == TMO;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      // Flags and data live for exactly the done cycle.
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            cnt   <= 16'd0;
            if (bad_f3) begin
              ill_q <= 1'b1;
              state <= FAULT;
            end else if (bad_align) begin
              mis_q <= 1'b1;
              state <= FAULT;
            end else begin
              addr_q  <= {addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          if (mem.ready) begin
            rdata_q <= we_q ? 32'd0 : ld;
            state   <= RESP;
          end else if (expire) begin
            berr_q <= 1'b1;
            state  <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && req_valid)
              || (state == ACCESS);
  assign done  = (state == RESP) || (state == FAULT);

  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign illegal    = ill_q;
  assign bus_error  = berr_q;

  assign mem.req   = state == ACCESS;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.be    = be_q;
  assign mem.wdata = wdata_q;

endmodule
